// File: rtl/rename_ctrl.sv
// Rename-stage sequencer: structural back-pressure, precise-exception recovery and stall counting.
// Optional macro RENAME_STALL_PERF_EN enables the stall_cnt register (otherwise tied to 0).
//
// state    | meaning
// RUN      | normal renaming, exceptions accepted
// FLUSH    | one-cycle flush pulse to rename table, ROB, IQs, LSU
// RECOVER  | architectural map / free list copy-back hold
// REDIRECT | one-cycle fetch redirect strobe
module rename_ctrl #(
    parameter int PC_W           = 32,
    parameter int RECOVER_CYCLES = 2,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_pc,
    input  logic                   full_PRF,
    input  logic                   full_ROB,
    input  logic                   full_IQ,
    input  logic                   excep_req,
    input  logic [PC_W-1:0]        excep_target,
    output logic                   freeze_front,
    output logic                   rename_fire,
    output logic                   flush,
    output logic                   redirect_valid,
    output logic [PC_W-1:0]        redirect_pc,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, RECOVER, REDIRECT} state_t;

    localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] rec_cnt;
    logic       struct_stall;
    logic       excep_accept;

    assign struct_stall = full_PRF | full_ROB | full_IQ;
    assign excep_accept = (state == RUN) & excep_req;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (excep_req) state_nxt = FLUSH;
            FLUSH:    state_nxt = (rec_cnt != 4'd0) ? RECOVER : REDIRECT;
            RECOVER:  if (rec_cnt == 4'd1) state_nxt = REDIRECT;
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        flush          = (state == FLUSH);
        redirect_valid = (state == REDIRECT);
        freeze_front   = struct_stall | (state != RUN) | excep_accept;
        rename_fire    = valid_pc & ~freeze_front;
    end

    // Target latched only on an accepted exception so it stays stable through REDIRECT and after.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_cnt     <= 4'd0;
            redirect_pc <= '0;
        end else if (excep_accept) begin
            rec_cnt     <= REC_LOAD;
            redirect_pc <= excep_target;
        end else if (state == RECOVER) begin
            rec_cnt     <= rec_cnt - 4'd1;
        end
    end

`ifdef RENAME_STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (valid_pc & freeze_front & ~(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule
